fetch_prefetch: RTL and testbench
=================================

# fetch_prefetch

Parametrised LC-3 instruction fetch unit with an in-order prefetch queue. It sits between the instruction memory port and decode: it streams sequential fetches into a DEPTH-entry queue tagged with their PCs, and resolves BR/JMP redirects by flushing the queue and retargeting the fetch PC. It keeps the existing fetch control inputs (`opCode_in`, `offset_in`, `reg_in`, `br_nzp`, `result_nzp`) and adds a valid/ready instruction output.

## Interface

- ADDR_W, 16, address and PC width
- DATA_W, 16, instruction width
- DEPTH, 4, prefetch queue entries (power of two, ≥2)
- RESET_PC, 0, PC value after reset

Ports:

- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  reset; asynchronous, active-low
- fetch_start  in  1  level; high enables issuing fetches
- ctrl_valid  in  1  one-cycle pulse; a control instruction has resolved
- opCode_in  in  4  opcode of resolving instruction (0000 BR, 1100 JMP; others ignored)
- offset_in  in  9  BR PCoffset9
- reg_in  in  ADDR_W  JMP base register value
- br_nzp  in  3  BR condition bits
- result_nzp  in  3  current condition codes
- ctrl_npc_in  in  ADDR_W  incremented PC of the resolving instruction
- addr_out  out  ADDR_W  memory read address (registered)
- rd_en_out  out  1  memory read strobe (registered)
- wea_out  out  1  memory write enable; constant 0
- mem_data_in  in  DATA_W  read data; valid the cycle after the request cycle
- instr_valid  out  1  queue head valid
- instr_out  out  DATA_W  queue head instruction
- instr_pc  out  ADDR_W  address of head instruction
- instr_ready  in  1  consumer accepts head when high with instr_valid
- pc  out  ADDR_W  next fetch address

## Operation

- Reset: pc=RESET_PC; addr_out=0, rd_en_out=0, wea_out=0, instr_valid=0, instr_out=0, instr_pc=0; queue empty; outstanding=0; state IDLE.
- States: IDLE (no issue), RUN (issue when room), DRAIN (fetch_start low, outstanding response pending).
  - IDLE→RUN when fetch_start=1. RUN→DRAIN when fetch_start=0 and outstanding>0, else →IDLE. DRAIN→IDLE when outstanding reaches 0; DRAIN→RUN if fetch_start returns.
- Issue: in RUN, issue a request (rd_en_out=1, addr_out=pc, pc←pc+1) only if occupancy+outstanding+1 ≤ DEPTH; otherwise hold rd_en_out=0 and pc.
- Response: the cycle after a request, mem_data_in is written at tail with the request's address as tag.
- Pop: instr_valid && instr_ready removes head. Push and pop in the same cycle are allowed when full (net occupancy unchanged).
- Redirect, when ctrl_valid=1:
  - BR taken iff |(br_nzp & result_nzp); target = ctrl_npc_in + sext(offset_in).
  - JMP always taken; target = reg_in.
  - Taken: the queue is flushed, any in-flight response is discarded (epoch bit), pc←target, and the pop of that cycle is ignored. Not taken: no effect.
- Arithmetic is modulo 2^ADDR_W: the pc wraps from all-ones to 0, and target addition wraps.

## Timing

- fetch_start sampled high at edge E0: rd_en_out=1, addr_out=pc after E0; data is captured at E2; instr_valid=1 after E2 (3-cycle latency).
- Steady state: one instruction per cycle with instr_ready held high.
- Redirect sampled at edge R: instr_valid=0 after R; first request to target after R+1; its instruction is valid after R+3.
- Async reset at any point aborts outstanding requests. A response arriving after reset release is not expected, because none was outstanding.

## Configuration

- FETCH_PREFETCH_BYPASS_EN defined: a response arriving while the queue is empty (and not being discarded) drives instr_valid/instr_out/instr_pc combinationally in the same cycle. If it is popped, it is not written to the queue. Latency becomes 2 cycles.
- Undefined: all outputs come from queue registers; latency 3.

## Test plan

- Reset 5 cycles, opCode_in=1100, ctrl_valid=0, fetch_start=0, then release -> addr_out=0, wea_out=0, pc=0, rd_en_out=0, instr_valid=0, held indefinitely.
- fetch_start=1, mem[a]=a^16'hA5A5, instr_ready=1 -> instr_pc=0,1,2,… with instr_out matching, first valid 3 cycles after start (2 with bypass).
- instr_ready=0, DEPTH=4 -> exactly 4 entries, rd_en_out stays 0, pc=4. Release -> PCs 0..3 in order, no loss or duplicate.
- JMP ctrl_valid, reg_in=16'h4000, mid-stream -> instr_valid drops next cycle, next addr_out=16'h4000, no stale instruction delivered.
- BR br_nzp=010, result_nzp=001 -> no flush. br_nzp=010, result_nzp=010, offset_in=9'h1FE, ctrl_npc_in=16'h0010 -> target 16'h000E.
- RESET_PC=16'hFFFE, fetch_start=1 -> addr_out FFFE, FFFF, 0000; instr_pc tags identical.

Source files
------------

// File: rtl/fetch_prefetch_if.sv
// -----------------------------------------------------------------------------
// fetch_prefetch_if
//
// Purpose: groups the instruction-memory read port and the decoded-instruction
// output stream of the fetch/prefetch unit into one bundle.
//
// Signals:
//   addr_out     memory read address (driven by fetch unit, registered)
//   rd_en_out    memory read strobe (driven by fetch unit, registered)
//   wea_out      memory write enable (driven by fetch unit, always 0)
//   mem_data_in  memory read data, valid the cycle after the request cycle
//   instr_valid  queue head valid (driven by fetch unit)
//   instr_out    queue head instruction (driven by fetch unit)
//   instr_pc     address of the head instruction (driven by fetch unit)
//   instr_ready  consumer accepts the head when high together with instr_valid
//
// Modports:
//   master  the fetch unit side
//   slave   the memory / decode side
//
// Handshake: an instruction transfers on a rising edge where instr_valid and
// instr_ready are both high; instr_valid/instr_out/instr_pc are stable while
// instr_valid is high and instr_ready is low, except that a taken redirect
// withdraws the head.
// -----------------------------------------------------------------------------
interface fetch_prefetch_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0] addr_out;
    logic              rd_en_out;
    logic              wea_out;
    logic [DATA_W-1:0] mem_data_in;
    logic              instr_valid;
    logic [DATA_W-1:0] instr_out;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_ready;

    modport master (
        output addr_out,
        output rd_en_out,
        output wea_out,
        input  mem_data_in,
        output instr_valid,
        output instr_out,
        output instr_pc,
        input  instr_ready
    );

    modport slave (
        input  addr_out,
        input  rd_en_out,
        input  wea_out,
        output mem_data_in,
        input  instr_valid,
        input  instr_out,
        input  instr_pc,
        output instr_ready
    );
endinterface

// File: rtl/fetch_prefetch.sv
// -----------------------------------------------------------------------------
// fetch_prefetch
//
// Purpose: LC-3 instruction fetch unit with an in-order prefetch queue.
// Sequential fetches are streamed into a DEPTH-entry queue, each entry tagged
// with the PC it was fetched from. A resolving BR (taken) or JMP flushes the
// queue, discards any in-flight response and retargets the fetch PC.
//
// Optional feature: define FETCH_PREFETCH_BYPASS_EN to let a response that
// arrives while the queue is empty drive the instruction outputs in the same
// cycle (2-cycle latency instead of 3).
//
// Ports:
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   fetch_start  level, enables issuing fetches
//   ctrl_valid   one-cycle pulse, a control instruction has resolved
//   opCode_in    opcode of the resolving instruction (0000 BR, 1100 JMP)
//   offset_in    BR PCoffset9
//   reg_in       JMP base register value
//   br_nzp       BR condition bits
//   result_nzp   current condition codes
//   ctrl_npc_in  incremented PC of the resolving instruction
//   pc           next fetch address
//   state_o      FSM state (0 IDLE, 1 RUN, 2 DRAIN)
//   bus          memory read port + instruction stream (master modport)
// -----------------------------------------------------------------------------
module fetch_prefetch #(
    parameter int                ADDR_W   = 16,
    parameter int                DATA_W   = 16,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_start,
    input  logic              ctrl_valid,
    input  logic [3:0]        opCode_in,
    input  logic [8:0]        offset_in,
    input  logic [ADDR_W-1:0] reg_in,
    input  logic [2:0]        br_nzp,
    input  logic [2:0]        result_nzp,
    input  logic [ADDR_W-1:0] ctrl_npc_in,
    output logic [ADDR_W-1:0] pc,
    output logic [1:0]        state_o,
    fetch_prefetch_if.master  bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SUM_W = CNT_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Fetch PC and the registered request stage (stage A: request on the bus).
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rd_en_q, rd_en_d;
    logic              a_epoch_q;

    // Stage B: the request of the previous cycle, whose data is on
    // mem_data_in in this cycle.
    logic              b_valid_q;
    logic              b_epoch_q;
    logic [ADDR_W-1:0] b_addr_q;

    // Epoch toggles on every taken redirect; any request carrying the old
    // epoch is dropped when its data arrives.
    logic              epoch_q, epoch_d;

    // Queue storage; pointers carry one extra bit so full and empty differ.
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [ADDR_W-1:0] tag_q  [DEPTH];
    logic [CNT_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_idx, rd_idx;
    logic [CNT_W-1:0]  count;
    logic              q_empty;

    logic              is_br, is_jmp, taken;
    logic [ADDR_W-1:0] target;
    logic              a_live, b_live;
    logic [1:0]        outstanding;
    logic [SUM_W-1:0]  need;
    logic              room, issue;
    logic              resp_ok, bypass_hit;
    logic              head_valid;
    logic [DATA_W-1:0] head_data;
    logic [ADDR_W-1:0] head_pc;
    logic              pop, q_pop, q_push;

    // ---------------------------------------------------------------- redirect
    assign is_br  = (opCode_in == 4'b0000);
    assign is_jmp = (opCode_in == 4'b1100);
    assign taken  = ctrl_valid && (is_jmp || (is_br && (|(br_nzp & result_nzp))));
    assign target = is_jmp ? reg_in
                           : ctrl_npc_in + {{(ADDR_W-9){offset_in[8]}}, offset_in};

    // ------------------------------------------------------------- occupancy
    assign wr_idx  = wr_ptr_q[PTR_W-1:0];
    assign rd_idx  = rd_ptr_q[PTR_W-1:0];
    assign count   = wr_ptr_q - rd_ptr_q;
    assign q_empty = (count == '0);

    // Only requests of the current epoch will ever land in the queue, so
    // only those reserve a slot.
    assign a_live      = rd_en_q   && (a_epoch_q == epoch_q);
    assign b_live      = b_valid_q && (b_epoch_q == epoch_q);
    assign outstanding = {1'b0, a_live} + {1'b0, b_live};
    assign need        = SUM_W'(count) + SUM_W'(outstanding) + SUM_W'(1);
    assign room        = (need <= SUM_W'(DEPTH));

    // A request goes out on the same edge fetch_start is first seen, so IDLE
    // and DRAIN also issue when fetch_start is high; the redirect cycle never
    // issues because the new target only becomes pc at that edge.
    assign issue = fetch_start && room && !taken;

    // --------------------------------------------------------------- response
    assign resp_ok = b_live && !taken;

`ifdef FETCH_PREFETCH_BYPASS_EN
    assign bypass_hit = resp_ok && q_empty;
`else
    assign bypass_hit = 1'b0;
`endif

    always_comb begin
        head_valid = !q_empty;
        head_data  = data_q[rd_idx];
        head_pc    = tag_q[rd_idx];
        if (bypass_hit) begin
            head_valid = 1'b1;
            head_data  = bus.mem_data_in;
            head_pc    = b_addr_q;
        end
    end

    assign pop    = head_valid && bus.instr_ready && !taken;
    assign q_pop  = pop && !q_empty;
    // A bypassed response that is consumed immediately never enters the queue.
    assign q_push = resp_ok && !(bypass_hit && pop);

    // -------------------------------------------------------- next-state data
    always_comb begin
        pc_d     = pc_q;
        addr_d   = addr_q;
        rd_en_d  = issue;
        epoch_d  = epoch_q ^ taken;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;

        if (taken) begin
            pc_d = target;
        end else if (issue) begin
            pc_d = pc_q + 1'b1;
        end

        if (issue) begin
            addr_d = pc_q;
        end

        if (taken) begin
            rd_ptr_d = wr_ptr_q;
        end else begin
            if (q_push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (q_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
        end
    end

    // ----------------------------------------------------------------- FSM
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (fetch_start) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!fetch_start) begin
                    state_d = (outstanding != 2'd0) ? ST_DRAIN : ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (fetch_start) begin
                    state_d = ST_RUN;
                end else if (outstanding == 2'd0) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------ registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q      <= RESET_PC;
            addr_q    <= '0;
            rd_en_q   <= 1'b0;
            a_epoch_q <= 1'b0;
            b_valid_q <= 1'b0;
            b_epoch_q <= 1'b0;
            b_addr_q  <= '0;
            epoch_q   <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
        end else begin
            pc_q      <= pc_d;
            addr_q    <= addr_d;
            rd_en_q   <= rd_en_d;
            a_epoch_q <= epoch_q;
            b_valid_q <= rd_en_q;
            b_epoch_q <= a_epoch_q;
            b_addr_q  <= addr_q;
            epoch_q   <= epoch_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
                tag_q[i]  <= '0;
            end
        end else if (q_push) begin
            data_q[wr_idx] <= bus.mem_data_in;
            tag_q[wr_idx]  <= b_addr_q;
        end
    end

    // --------------------------------------------------------------- outputs
    assign pc              = pc_q;
    assign state_o         = state_q;
    assign bus.addr_out    = addr_q;
    assign bus.rd_en_out   = rd_en_q;
    assign bus.wea_out     = 1'b0;
    assign bus.instr_valid = head_valid;
    assign bus.instr_out   = head_data;
    assign bus.instr_pc    = head_pc;

endmodule

// File: tb/tb_fetch_prefetch.sv
`timescale 1ns/1ps
module tb_fetch_prefetch;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int DEPTH = 4;
`ifdef FETCH_PREFETCH_BYPASS_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 3;
`endif

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          fetch_start, fetch_start_w, ctrl_valid, tb_flush;
  logic [3:0]    opCode_in;
  logic [8:0]    offset_in;
  logic [AW-1:0] reg_in, ctrl_npc_in, pc, pc_w;
  logic [2:0]    br_nzp, result_nzp;
  logic [1:0]    state, state_w;

  fetch_prefetch_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  fetch_prefetch_if #(.ADDR_W(AW), .DATA_W(DW)) bus_w ();

  fetch_prefetch #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .RESET_PC(16'h0000)) u_dut (
    .clk(clk), .rst_n(rst_n), .fetch_start(fetch_start), .ctrl_valid(ctrl_valid),
    .opCode_in(opCode_in), .offset_in(offset_in), .reg_in(reg_in), .br_nzp(br_nzp),
    .result_nzp(result_nzp), .ctrl_npc_in(ctrl_npc_in), .pc(pc), .state_o(state), .bus(bus)
  );

  fetch_prefetch #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .RESET_PC(16'hFFFE)) u_dut_w (
    .clk(clk), .rst_n(rst_n), .fetch_start(fetch_start_w), .ctrl_valid(1'b0),
    .opCode_in(4'b0000), .offset_in(9'h000), .reg_in(16'h0000), .br_nzp(3'b000),
    .result_nzp(3'b000), .ctrl_npc_in(16'h0000), .pc(pc_w), .state_o(state_w), .bus(bus_w)
  );

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return a ^ 16'hA5A5;
  endfunction

  // Instruction memories: data valid the cycle after the request cycle.
  always @(posedge clk) if (bus.rd_en_out) bus.mem_data_in <= mem_word(bus.addr_out);
  always @(posedge clk) if (bus_w.rd_en_out) bus_w.mem_data_in <= mem_word(bus_w.addr_out);

  // ---------------------------------------------------------------- scoreboard
  logic [AW-1:0] exp_q[$];
  logic [AW-1:0] obs_pc_q[$];
  logic [DW-1:0] obs_data_q[$];
  int checks = 0;
  int failures = 0;

  // Accepted instructions, sampled away from the active edge.
  always @(negedge clk) begin
    if (rst_n && bus.instr_valid && bus.instr_ready && !tb_flush) begin
      obs_pc_q.push_back(bus.instr_pc);
      obs_data_q.push_back(bus.instr_out);
    end
  end

  // ---------------------------------------------------------------- drivers
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    fetch_start = 1'b0; fetch_start_w = 1'b0; ctrl_valid = 1'b0; tb_flush = 1'b0;
    opCode_in = 4'b1100; offset_in = 9'h000; reg_in = '0; br_nzp = 3'b000;
    result_nzp = 3'b000; ctrl_npc_in = '0;
    bus.instr_ready = 1'b0; bus_w.instr_ready = 1'b0;
    repeat (5) step();
    rst_n = 1'b1;
    obs_pc_q.delete(); obs_data_q.delete(); exp_q.delete();
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (bus.addr_out !== 16'h0000) begin failures++; $display("FAIL reset_addr cyc=%0d got=%h exp=0000", i, bus.addr_out); end
      checks++; if (bus.wea_out !== 1'b0) begin failures++; $display("FAIL reset_wea cyc=%0d got=%b exp=0", i, bus.wea_out); end
      checks++; if (pc !== 16'h0000) begin failures++; $display("FAIL reset_pc cyc=%0d got=%h exp=0000", i, pc); end
      checks++; if (bus.rd_en_out !== 1'b0) begin failures++; $display("FAIL reset_rd_en cyc=%0d got=%b exp=0", i, bus.rd_en_out); end
      checks++; if (bus.instr_valid !== 1'b0) begin failures++; $display("FAIL reset_valid cyc=%0d got=%b exp=0", i, bus.instr_valid); end
      checks++; if (bus.instr_out !== 16'h0000 || bus.instr_pc !== 16'h0000) begin failures++; $display("FAIL reset_instr cyc=%0d got=%h/%h exp=0000/0000", i, bus.instr_out, bus.instr_pc); end
      checks++; if (state !== 2'd0) begin failures++; $display("FAIL reset_state cyc=%0d got=%0d exp=0", i, state); end
      checks++; if (pc_w !== 16'hFFFE) begin failures++; $display("FAIL reset_pc_w cyc=%0d got=%h exp=FFFE", i, pc_w); end
    end
  endtask

  task automatic test_stream();
    logic [AW-1:0] e;
    apply_reset();
    bus.instr_ready = 1'b1;
    fetch_start = 1'b1;
    for (int k = 0; k < 12; k++) begin
      step();
      checks++; if (bus.rd_en_out !== 1'b1 || bus.addr_out !== 16'(k)) begin failures++; $display("FAIL stream_req k=%0d got=%b/%h exp=1/%h", k, bus.rd_en_out, bus.addr_out, 16'(k)); end
      checks++; if (pc !== 16'(k + 1)) begin failures++; $display("FAIL stream_pc k=%0d got=%h exp=%h", k, pc, 16'(k + 1)); end
      checks++; if (bus.instr_valid !== (k >= LAT - 1)) begin failures++; $display("FAIL stream_valid k=%0d got=%b exp=%b", k, bus.instr_valid, (k >= LAT - 1)); end
      if (k >= LAT - 1) begin
        e = 16'(k - (LAT - 1));
        checks++; if (bus.instr_pc !== e || bus.instr_out !== mem_word(e)) begin failures++; $display("FAIL stream_head k=%0d got=%h/%h exp=%h/%h", k, bus.instr_pc, bus.instr_out, e, mem_word(e)); end
      end
    end
    checks++; if (state !== 2'd1) begin failures++; $display("FAIL stream_state got=%0d exp=1", state); end
  endtask

  task automatic test_backpressure();
    apply_reset();
    bus.instr_ready = 1'b0;
    fetch_start = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      checks++; if (bus.rd_en_out !== (k < DEPTH)) begin failures++; $display("FAIL bp_rd_en k=%0d got=%b exp=%b", k, bus.rd_en_out, (k < DEPTH)); end
    end
    checks++; if (pc !== 16'h0004) begin failures++; $display("FAIL bp_pc got=%h exp=0004", pc); end
    checks++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 16'h0000 || bus.instr_out !== mem_word(16'h0000)) begin failures++; $display("FAIL bp_head got=%b/%h/%h exp=1/0000/%h", bus.instr_valid, bus.instr_pc, bus.instr_out, mem_word(16'h0000)); end
    bus.instr_ready = 1'b1;
    fetch_start = 1'b0;
    for (int i = 0; i < DEPTH; i++) exp_q.push_back(16'(i));
    repeat (8) step();
    checks++; if (bus.instr_valid !== 1'b0 || state !== 2'd0) begin failures++; $display("FAIL bp_idle got=%b/%0d exp=0/0", bus.instr_valid, state); end
    checks++; if (obs_pc_q.size() != exp_q.size()) begin failures++; $display("FAIL bp_count got=%0d exp=%0d", obs_pc_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_pc_q.size(); i++) begin
      checks++; if (obs_pc_q[i] !== exp_q[i] || obs_data_q[i] !== mem_word(exp_q[i])) begin failures++; $display("FAIL bp_order i=%0d got=%h/%h exp=%h/%h", i, obs_pc_q[i], obs_data_q[i], exp_q[i], mem_word(exp_q[i])); end
    end
  endtask

  task automatic test_jmp();
    apply_reset();
    bus.instr_ready = 1'b1;
    fetch_start = 1'b1;
    repeat (8) step();
    ctrl_valid = 1'b1; opCode_in = 4'b1100; reg_in = 16'h4000; tb_flush = 1'b1;
    step();
    ctrl_valid = 1'b0; tb_flush = 1'b0;
    checks++; if (bus.instr_valid !== 1'b0 || pc !== 16'h4000 || bus.rd_en_out !== 1'b0) begin failures++; $display("FAIL jmp_flush got=%b/%h/%b exp=0/4000/0", bus.instr_valid, pc, bus.rd_en_out); end
    step();
    checks++; if (bus.rd_en_out !== 1'b1 || bus.addr_out !== 16'h4000 || bus.instr_valid !== 1'b0) begin failures++; $display("FAIL jmp_req got=%b/%h/%b exp=1/4000/0", bus.rd_en_out, bus.addr_out, bus.instr_valid); end
    repeat (6) step();
    fetch_start = 1'b0;
    step();
    checks++; if (state !== 2'd2) begin failures++; $display("FAIL jmp_drain_state got=%0d exp=2", state); end
    repeat (8) step();
    checks++; if (state !== 2'd0 || bus.instr_valid !== 1'b0) begin failures++; $display("FAIL jmp_idle got=%0d/%b exp=0/0", state, bus.instr_valid); end
    for (int i = 0; i < 8 - LAT; i++) exp_q.push_back(16'(i));
    for (int i = 0; i < 7; i++) exp_q.push_back(16'h4000 + 16'(i));
    checks++; if (obs_pc_q.size() != exp_q.size()) begin failures++; $display("FAIL jmp_count got=%0d exp=%0d", obs_pc_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_pc_q.size(); i++) begin
      checks++; if (obs_pc_q[i] !== exp_q[i] || obs_data_q[i] !== mem_word(exp_q[i])) begin failures++; $display("FAIL jmp_order i=%0d got=%h/%h exp=%h/%h", i, obs_pc_q[i], obs_data_q[i], exp_q[i], mem_word(exp_q[i])); end
    end
  endtask

  task automatic test_br();
    logic [AW-1:0] e;
    apply_reset();
    bus.instr_ready = 1'b1;
    fetch_start = 1'b1;
    repeat (8) step();
    // Not taken: condition bits do not overlap.
    ctrl_valid = 1'b1; opCode_in = 4'b0000; br_nzp = 3'b010; result_nzp = 3'b001;
    offset_in = 9'h1FE; ctrl_npc_in = 16'h0010; tb_flush = 1'b0;
    step();
    ctrl_valid = 1'b0;
    e = 16'(8 - (LAT - 1));
    checks++; if (pc !== 16'h0009 || bus.instr_valid !== 1'b1 || bus.instr_pc !== e) begin failures++; $display("FAIL br_nt got=%h/%b/%h exp=0009/1/%h", pc, bus.instr_valid, bus.instr_pc, e); end
    // Taken: target 0x0010 + (-2).
    result_nzp = 3'b010; ctrl_valid = 1'b1; tb_flush = 1'b1;
    step();
    ctrl_valid = 1'b0; tb_flush = 1'b0;
    checks++; if (pc !== 16'h000E || bus.instr_valid !== 1'b0) begin failures++; $display("FAIL br_taken got=%h/%b exp=000E/0", pc, bus.instr_valid); end
    step();
    checks++; if (bus.rd_en_out !== 1'b1 || bus.addr_out !== 16'h000E) begin failures++; $display("FAIL br_req got=%b/%h exp=1/000E", bus.rd_en_out, bus.addr_out); end
    repeat (6) step();
    fetch_start = 1'b0;
    repeat (9) step();
    for (int i = 0; i < 9 - LAT; i++) exp_q.push_back(16'(i));
    for (int i = 0; i < 7; i++) exp_q.push_back(16'h000E + 16'(i));
    checks++; if (obs_pc_q.size() != exp_q.size()) begin failures++; $display("FAIL br_count got=%0d exp=%0d", obs_pc_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_pc_q.size(); i++) begin
      checks++; if (obs_pc_q[i] !== exp_q[i] || obs_data_q[i] !== mem_word(exp_q[i])) begin failures++; $display("FAIL br_order i=%0d got=%h/%h exp=%h/%h", i, obs_pc_q[i], obs_data_q[i], exp_q[i], mem_word(exp_q[i])); end
    end
  endtask

  task automatic test_wrap();
    logic [AW-1:0] e;
    apply_reset();
    bus_w.instr_ready = 1'b1;
    fetch_start_w = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      if (k < 3) begin
        e = 16'hFFFE + 16'(k);
        checks++; if (bus_w.rd_en_out !== 1'b1 || bus_w.addr_out !== e) begin failures++; $display("FAIL wrap_addr k=%0d got=%b/%h exp=1/%h", k, bus_w.rd_en_out, bus_w.addr_out, e); end
        e = 16'hFFFE + 16'(k + 1);
        checks++; if (pc_w !== e) begin failures++; $display("FAIL wrap_pc k=%0d got=%h exp=%h", k, pc_w, e); end
      end
      if (k >= LAT - 1 && k - (LAT - 1) < 3) begin
        e = 16'hFFFE + 16'(k - (LAT - 1));
        checks++; if (bus_w.instr_valid !== 1'b1 || bus_w.instr_pc !== e || bus_w.instr_out !== mem_word(e)) begin failures++; $display("FAIL wrap_tag k=%0d got=%b/%h/%h exp=1/%h/%h", k, bus_w.instr_valid, bus_w.instr_pc, bus_w.instr_out, e, mem_word(e)); end
      end
    end
  endtask

  // ---------------------------------------------------------------- sequence
  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_jmp();
    test_br();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
